bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL provide parameter RAM_WORDS, default 256, the number of 32-bit data RAM words (power of 2, maximum 256).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port iMemAddr  input  32  byte address from core MEM stage.
REQ-005 SHALL have port iMemRead  input  1  read strobe.
REQ-006 SHALL have port iMemWrite  input  1  write strobe.
REQ-007 SHALL have port iMemWriteData  input  32  store data.
REQ-008 SHALL have port oMemReadData  output  32  load data, combinational from address.
REQ-009 SHALL have port oInterrupt  output  1  timer interrupt request to core.
REQ-010 SHALL have port oLed  output  8  LED register.
REQ-011 SHALL have port iSwitch  input  8  switch inputs, already synchronous to clk.

Function
REQ-012 SHALL decode the address map as follows; iMemAddr[1:0] is ignored for every region:
- 0x00000000-0x000003FF: data RAM, word index iMemAddr[9:2] modulo RAM_WORDS.
- 0x40000000: TH.
- 0x40000004: TL.
- 0x40000008: TCON[2:0].
- 0x4000000C: LED[7:0].
- 0x40000010: switch, read-only.
- 0x40000014: systick, read-only.
REQ-013 SHALL drive oMemReadData combinationally (zero latency) with the addressed value when iMemRead=1, zero-extended for narrow registers; SHALL drive 0 when iMemRead=0 or the address is unmapped.
REQ-014 SHALL commit writes at the rising clk edge when iMemWrite=1; writes to unmapped or read-only addresses SHALL be ignored.
REQ-015 SHALL return the new value on a read of the same address one cycle after a write (no bypass within the write cycle).
REQ-016 SHALL use TCON bits as follows: [0] timer enable, [1] interrupt enable, [2] interrupt status.
REQ-017 SHALL, when TCON[0]=1, increment TL each cycle; when TL=0xFFFFFFFF, SHALL load TL<=TH instead and set TCON[2]<=1 if TCON[1]=1.
REQ-018 SHALL drive oInterrupt = TCON[1] & TCON[2], registered, with no combinational path from the bus.
REQ-019 SHALL clear TCON[2] only by software writing TCON with bit 2 = 0.
REQ-020 SHALL give a bus write to TL priority over the same-cycle increment or reload.
REQ-021 SHALL, on a TCON write coinciding with a TL overflow while TCON[1] (pre-write) =1, set TCON[2]=1 (interrupt not lost) and take bits [1:0] from the written data.
REQ-022 SHALL commit the written TH value and reload the old TH value when a TH write coincides with overflow.
REQ-023 SHALL handle iMemRead and iMemWrite both set as a normal write plus a read of the old value.

Reset
REQ-024 SHALL, on reset low, asynchronously clear TH, TL, TCON, LED and systick to 0, so that oInterrupt=0, oLed=0 and oMemReadData follows REQ-013.
REQ-025 SHALL leave data RAM contents unaffected by reset.
REQ-026 SHALL abandon any write pending in the cycle reset asserts; no register takes bus data while reset is low.

Configuration
REQ-027 SHALL, with PERIPH_SYSTICK_EN defined, implement a 32-bit free-running systick counter that increments every cycle, wraps 0xFFFFFFFF->0 and reads at 0x40000014.
REQ-028 SHALL, without PERIPH_SYSTICK_EN, implement no systick counter; 0x40000014 then reads 0 like an unmapped address.

Verification
REQ-029 SHALL cover: write 0xDEADBEEF to 0x00000010, next cycle read 0x00000010 and 0x00000013 -> both return 0xDEADBEEF; read 0x00000014 -> not 0xDEADBEEF.
REQ-030 SHALL cover: TH=0xFFFFFFF0, TL=0xFFFFFFFD, TCON=3 -> oInterrupt rises exactly 3 cycles after TCON write commits; TL then reads 0xFFFFFFF0 plus elapsed cycles.
REQ-031 SHALL cover: with interrupt pending, write TCON=3 -> oInterrupt low next cycle; the same write coincident with an overflow -> oInterrupt stays 1.
REQ-032 SHALL cover: iSwitch=0xA5, read 0x40000010 -> 0x000000A5; write 0x1234_5678 to 0x4000000C -> oLed=0x78; write to 0x40000010 -> no effect.
REQ-033 SHALL cover: assert reset mid-count with TCON=3 -> oLed, oInterrupt, TL, TCON read 0 immediately without a clock edge; RAM word written earlier still reads back.
REQ-034 SHALL cover: systick read twice 5 cycles apart -> difference 5 with PERIPH_SYSTICK_EN, 0 and 0 without it.

Source files
------------

// File: rtl/bus_responder.sv
// Memory-mapped bus responder: word RAM, interval timer with interrupt, LED and switch ports.
// Defining PERIPH_SYSTICK_EN adds a free-running systick counter readable at 0x40000014.
module bus_responder #(
   parameter int RAM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] iMemAddr,
   input  logic        iMemRead,
   input  logic        iMemWrite,
   input  logic [31:0] iMemWriteData,
   output logic [31:0] oMemReadData,
   output logic        oInterrupt,
   output logic [7:0]  oLed,
   input  logic [7:0]  iSwitch
);

   localparam int IDX_W = $clog2(RAM_WORDS);

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_TH,
      SEL_TL,
      SEL_TCON,
      SEL_LED,
      SEL_SW,
      SEL_TICK
   } sel_t;

   typedef struct packed {
      logic irq_stat;
      logic irq_en;
      logic tmr_en;
   } tcon_t;

   logic [31:0]      word_addr;
   logic [IDX_W-1:0] ram_idx;
   sel_t             sel;

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] th;
   logic [31:0] tl;
   logic [31:0] tl_next;
   tcon_t       tcon;
   tcon_t       tcon_next;
   logic [7:0]  led;
   logic        overflow;
   logic        stat_set;

   // Byte offset within a word never takes part in decoding.
   assign word_addr = iMemAddr & ~32'd3;
   assign ram_idx   = word_addr[2 +: IDX_W];

   always_comb begin
      sel = SEL_NONE;
      if (word_addr[31:10] == 22'd0) begin
         sel = SEL_RAM;
      end else begin
         case (word_addr)
            32'h4000_0000: sel = SEL_TH;
            32'h4000_0004: sel = SEL_TL;
            32'h4000_0008: sel = SEL_TCON;
            32'h4000_000C: sel = SEL_LED;
            32'h4000_0010: sel = SEL_SW;
`ifdef PERIPH_SYSTICK_EN
            32'h4000_0014: sel = SEL_TICK;
`endif
            default:       sel = SEL_NONE;
         endcase
      end
   end

   // NOTE: the RAM array has no reset branch so it maps onto block RAM and keeps its
   // contents through reset; the reset level still gates the write enable.
   always_ff @(posedge clk) begin
      if (reset && iMemWrite && (sel == SEL_RAM)) begin
         ram[ram_idx] <= iMemWriteData;
      end
   end

   assign overflow = tcon.tmr_en && (tl == 32'hFFFF_FFFF);
   assign stat_set = overflow && tcon.irq_en;

   // A bus write to TL beats the timer's own increment or reload.
   always_comb begin
      tl_next = tl;
      if (iMemWrite && (sel == SEL_TL)) begin
         tl_next = iMemWriteData;
      end else if (tcon.tmr_en) begin
         tl_next = overflow ? th : tl + 32'd1;
      end
   end

   // NOTE: every signal assigned in always_comb takes a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      tcon_next = tcon;
      if (iMemWrite && (sel == SEL_TCON)) begin
         tcon_next = tcon_t'(iMemWriteData[2:0]);
      end
      // An overflow in the same cycle as a TCON write must not lose its interrupt.
      if (stat_set) begin
         tcon_next.irq_stat = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
         led  <= '0;
      end else begin
         tl   <= tl_next;
         tcon <= tcon_next;
         if (iMemWrite && (sel == SEL_TH)) begin
            th <= iMemWriteData;
         end
         if (iMemWrite && (sel == SEL_LED)) begin
            led <= iMemWriteData[7:0];
         end
      end
   end

`ifdef PERIPH_SYSTICK_EN
   logic [31:0] systick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         systick <= '0;
      end else begin
         systick <= systick + 32'd1;
      end
   end
`endif

   always_comb begin
      oMemReadData = '0;
      if (iMemRead) begin
         case (sel)
            SEL_RAM:  oMemReadData = ram[ram_idx];
            SEL_TH:   oMemReadData = th;
            SEL_TL:   oMemReadData = tl;
            SEL_TCON: oMemReadData = {29'd0, tcon};
            SEL_LED:  oMemReadData = {24'd0, led};
            SEL_SW:   oMemReadData = {24'd0, iSwitch};
`ifdef PERIPH_SYSTICK_EN
            SEL_TICK: oMemReadData = systick;
`endif
            default:  oMemReadData = '0;
         endcase
      end
   end

   // Both terms come straight from flops, so the interrupt has no path from the bus.
   assign oInterrupt = tcon.irq_en & tcon.irq_stat;
   assign oLed       = led;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed vector table, timer corner sequences,
// and a randomized run compared against a behavioural model of the address map.
module tb_bus_responder;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;
   localparam logic [31:0] A_SW   = 32'h4000_0010;
   localparam logic [31:0] A_TICK = 32'h4000_0014;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iMemAddr;
   logic        iMemRead;
   logic        iMemWrite;
   logic [31:0] iMemWriteData;
   logic [31:0] oMemReadData;
   logic        oInterrupt;
   logic [7:0]  oLed;
   logic [7:0]  iSwitch;

   int total = 0;
   int bad   = 0;

   bus_responder #(.RAM_WORDS(256)) dut (
      .clk           (clk),
      .reset         (reset),
      .iMemAddr      (iMemAddr),
      .iMemRead      (iMemRead),
      .iMemWrite     (iMemWrite),
      .iMemWriteData (iMemWriteData),
      .oMemReadData  (oMemReadData),
      .oInterrupt    (oInterrupt),
      .oLed          (oLed),
      .iSwitch       (iSwitch)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      iMemAddr      = a;
      iMemWriteData = d;
      iMemWrite     = 1'b1;
      @(posedge clk);
      #1;
      iMemWrite = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      iMemAddr = a;
      iMemRead = 1'b1;
      #1;
      d        = oMemReadData;
      iMemRead = 1'b0;
   endtask

   // Behavioural model of the responder state, used for the randomized run.
   logic [31:0] m_ram [256];
   bit          m_ok  [256];
   logic [31:0] m_th, m_tl, m_tick;
   logic [7:0]  m_led;
   bit          m_en, m_ie, m_st;

   task automatic model_reset();
      m_th = '0; m_tl = '0; m_tick = '0; m_led = '0;
      m_en = 0; m_ie = 0; m_st = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [7:0] sw,
                                              output bit known);
      logic [31:0] w = a & 32'hFFFF_FFFC;
      known = 1;
      if (w < 32'h400) begin
         known = m_ok[w[9:2]];
         return m_ram[w[9:2]];
      end
      case (w)
         A_TH:   return m_th;
         A_TL:   return m_tl;
         A_TCON: return {29'd0, m_st, m_ie, m_en};
         A_LED:  return {24'd0, m_led};
         A_SW:   return {24'd0, sw};
`ifdef PERIPH_SYSTICK_EN
         A_TICK: return m_tick;
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick_addr();
      int          k  = $urandom_range(0, 9);
      logic [31:0] lo = 32'($urandom_range(0, 3));
      case (k)
         0, 1, 2: return ($urandom & 32'h0000_03FC) | lo;
         3:       return A_TH | lo;
         4:       return A_TL | lo;
         5:       return A_TCON | lo;
         6:       return A_LED | lo;
         7:       return A_SW | lo;
         8:       return A_TICK | lo;
         default: begin
            case ($urandom_range(0, 3))
               0:       return 32'h0000_0400;
               1:       return 32'h4000_0018;
               2:       return 32'h8000_0000;
               default: return 32'h3FFF_FFFC;
            endcase
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_data(input logic [31:0] a);
      logic [31:0] w = a & 32'hFFFF_FFFC;
      case (w)
         A_TL:    return ($urandom_range(0, 3) != 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom);
         A_TH:    return ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                                     : 32'($urandom);
         A_TCON:  return 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'd3 : 32'd0);
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic rand_cycle();
      logic [31:0] a  = pick_addr();
      logic [31:0] w  = a & 32'hFFFF_FFFC;
      logic [31:0] d  = pick_data(a);
      logic        rd = 1'($urandom_range(0, 1));
      logic        wr = ($urandom_range(0, 2) == 0);
      logic [7:0]  sw = 8'($urandom);
      logic [31:0] exp_rd;
      bit          known;
      bit          ovf;
      logic [31:0] n_th, n_tl;
      logic [7:0]  n_led;
      bit          n_en, n_ie, n_st;

      iMemAddr = a; iMemRead = rd; iMemWrite = wr; iMemWriteData = d; iSwitch = sw;
      #1;
      exp_rd = model_read(a, sw, known);
      if (!rd) check("rnd_rd_idle", oMemReadData, 32'd0);
      else if (known) check("rnd_rd", oMemReadData, exp_rd);
      check("rnd_int", {31'd0, oInterrupt}, {31'd0, m_ie & m_st});
      check("rnd_led", {24'd0, oLed}, {24'd0, m_led});

      // Timer rule: count when enabled; past all-ones, restart from TH and flag if allowed.
      ovf   = m_en && (m_tl == 32'hFFFF_FFFF);
      n_th  = m_th;
      n_tl  = m_en ? (ovf ? m_th : m_tl + 32'd1) : m_tl;
      n_led = m_led;
      n_en  = m_en;
      n_ie  = m_ie;
      n_st  = m_st || (ovf && m_ie);
      if (wr) begin
         if (w < 32'h400) begin
            m_ram[w[9:2]] = d;
            m_ok[w[9:2]]  = 1;
         end
         case (w)
            A_TH:   n_th = d;
            A_TL:   n_tl = d;
            A_TCON: begin
               n_en = d[0];
               n_ie = d[1];
               n_st = d[2] || (ovf && m_ie);
            end
            A_LED:  n_led = d[7:0];
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      m_th = n_th; m_tl = n_tl; m_led = n_led;
      m_en = n_en; m_ie = n_ie; m_st = n_st;
      m_tick = m_tick + 32'd1;
      iMemRead = 1'b0; iMemWrite = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wd;
      logic [7:0]  sw;
      logic [31:0] exp_rd;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] v, t0, t1;

      reset = 1'b0; iMemAddr = '0; iMemRead = 0; iMemWrite = 0;
      iMemWriteData = '0; iSwitch = '0;
      idle(2);
      check("rst_led", {24'd0, oLed}, 32'd0);
      check("rst_int", {31'd0, oInterrupt}, 32'd0);
      reset = 1'b1;
      idle(1);

      vecs.push_back('{"rst_th",    A_TH,          1, 0, 32'h0,         8'h00, 32'h0,         8'h00});
      vecs.push_back('{"rst_tcon",  A_TCON,        1, 0, 32'h0,         8'h00, 32'h0,         8'h00});
      vecs.push_back('{"ram_wr",    32'h10,        0, 1, 32'hDEADBEEF,  8'h00, 32'h0,         8'h00});
      vecs.push_back('{"ram_wr2",   32'h14,        0, 1, 32'h11111111,  8'h00, 32'h0,         8'h00});
      vecs.push_back('{"ram_rd",    32'h10,        1, 0, 32'h0,         8'h00, 32'hDEADBEEF,  8'h00});
      vecs.push_back('{"ram_rd_b3", 32'h13,        1, 0, 32'h0,         8'h00, 32'hDEADBEEF,  8'h00});
      vecs.push_back('{"ram_rd_nb", 32'h14,        1, 0, 32'h0,         8'h00, 32'h11111111,  8'h00});
      vecs.push_back('{"rd_off",    32'h10,        0, 0, 32'h0,         8'h00, 32'h0,         8'h00});
      vecs.push_back('{"sw_rd",     A_SW,          1, 0, 32'h0,         8'hA5, 32'h000000A5,  8'h00});
      vecs.push_back('{"led_wr",    A_LED,         0, 1, 32'h12345678,  8'hA5, 32'h0,         8'h00});
      vecs.push_back('{"led_rd",    A_LED,         1, 0, 32'h0,         8'hA5, 32'h00000078,  8'h78});
      vecs.push_back('{"sw_wr",     A_SW,          0, 1, 32'hFFFFFFFF,  8'hA5, 32'h0,         8'h78});
      vecs.push_back('{"sw_ro",     A_SW,          1, 0, 32'h0,         8'hA5, 32'h000000A5,  8'h78});
      vecs.push_back('{"rw_same",   32'h10,        1, 1, 32'hCAFEF00D,  8'h00, 32'hDEADBEEF,  8'h78});
      vecs.push_back('{"rw_new",    32'h10,        1, 0, 32'h0,         8'h00, 32'hCAFEF00D,  8'h78});
      vecs.push_back('{"unm_wr",    32'h40000018,  0, 1, 32'h12345678,  8'h00, 32'h0,         8'h78});
      vecs.push_back('{"unm_rd",    32'h40000018,  1, 0, 32'h0,         8'h00, 32'h0,         8'h78});
      vecs.push_back('{"unm_ram",   32'h00000400,  1, 0, 32'h0,         8'h00, 32'h0,         8'h78});
      vecs.push_back('{"unm_hi",    32'h80000010,  1, 0, 32'h0,         8'h00, 32'h0,         8'h78});
      vecs.push_back('{"th_wr_b2",  32'h40000002,  0, 1, 32'h00000055,  8'h00, 32'h0,         8'h78});
      vecs.push_back('{"th_rd_b1",  32'h40000001,  1, 0, 32'h0,         8'h00, 32'h00000055,  8'h78});
      vecs.push_back('{"tl_idle",   A_TL,          1, 0, 32'h0,         8'h00, 32'h0,         8'h78});

      foreach (vecs[i]) begin
         iMemAddr = vecs[i].addr; iMemRead = vecs[i].rd; iMemWrite = vecs[i].wr;
         iMemWriteData = vecs[i].wd; iSwitch = vecs[i].sw;
         #1;
         check(vecs[i].name, oMemReadData, vecs[i].exp_rd);
         check({vecs[i].name, "_led"}, {24'd0, oLed}, {24'd0, vecs[i].exp_led});
         @(posedge clk);
         #1;
      end
      iMemRead = 0; iMemWrite = 0; iSwitch = 8'h00;

      // Interrupt rises three cycles after the enabling TCON write, then TL restarts at TH.
      bus_write(A_TH, 32'hFFFF_FFF0);
      bus_write(A_TL, 32'hFFFF_FFFD);
      bus_write(A_TCON, 32'd3);
      check("int_c0", {31'd0, oInterrupt}, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         idle(1);
         check($sformatf("int_c%0d", k), {31'd0, oInterrupt}, {31'd0, (k == 3)});
      end
      bus_read(A_TL, v);   check("tl_reload", v, 32'hFFFF_FFF0);
      bus_read(A_TCON, v); check("tcon_pend", v, 32'd7);
      idle(2);
      bus_read(A_TL, v);   check("tl_count", v, 32'hFFFF_FFF2);

      // Clearing the status, and a clearing write that coincides with an overflow.
      bus_write(A_TCON, 32'd3);
      check("int_clr", {31'd0, oInterrupt}, 32'd0);
      bus_write(A_TL, 32'hFFFF_FFFF);
      idle(1);
      check("int_ovf", {31'd0, oInterrupt}, 32'd1);
      bus_write(A_TL, 32'hFFFF_FFFF);
      bus_write(A_TCON, 32'd3);
      check("int_keep", {31'd0, oInterrupt}, 32'd1);
      bus_read(A_TL, v);   check("tl_after_keep", v, 32'hFFFF_FFF0);
      bus_read(A_TCON, v); check("tcon_keep", v, 32'd7);

      // TH written at overflow: TL takes the old TH, TH keeps the new value.
      bus_write(A_TL, 32'hFFFF_FFFF);
      bus_write(A_TH, 32'h0000_0100);
      bus_read(A_TL, v); check("th_wr_ovf_tl", v, 32'hFFFF_FFF0);
      bus_read(A_TH, v); check("th_wr_ovf_th", v, 32'h0000_0100);

      // TL written at overflow: the written value wins.
      bus_write(A_TL, 32'hFFFF_FFFF);
      bus_write(A_TL, 32'h0000_1234);
      bus_read(A_TL, v); check("tl_wr_prio", v, 32'h0000_1234);
      check("led_pre", {24'd0, oLed}, 32'h78);
      check("int_pre", {31'd0, oInterrupt}, 32'd1);

      // Reset mid-cycle clears registers without a clock edge; RAM survives.
      #1;
      reset = 1'b0;
      #1;
      check("rst_async_led", {24'd0, oLed}, 32'd0);
      check("rst_async_int", {31'd0, oInterrupt}, 32'd0);
      bus_read(A_TL, v);   check("rst_async_tl", v, 32'd0);
      bus_read(A_TCON, v); check("rst_async_tcon", v, 32'd0);
      bus_read(32'h10, v); check("rst_ram_keep", v, 32'hCAFEF00D);
      iMemAddr = A_LED; iMemWriteData = 32'hFF; iMemWrite = 1'b1;
      idle(1);
      iMemAddr = 32'h10; iMemWriteData = 32'h0;
      idle(1);
      iMemWrite = 1'b0;
      reset = 1'b1;
      check("rst_wr_led", {24'd0, oLed}, 32'd0);
      bus_read(32'h10, v); check("rst_wr_ram", v, 32'hCAFEF00D);

      // Systick: two reads five cycles apart.
      bus_read(A_TICK, t0);
      idle(5);
      bus_read(A_TICK, t1);
`ifdef PERIPH_SYSTICK_EN
      check("tick_diff", t1 - t0, 32'd5);
`else
      check("tick_zero0", t0, 32'd0);
      check("tick_zero1", t1, 32'd0);
`endif

      // Randomized run against the model, from a fresh reset.
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 256; i++) m_ok[i] = 0;
      for (int i = 0; i < 600; i++) rand_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
